// File: rtl/counter_timer_core.sv
// Prescaled hex/BCD up/down counter with clear, load, wrap flag and a free-running
// display clock; feeds the number and clock inputs of the quad 7-segment driver.
module counter_timer_core #(
  parameter int CLK_HZ   = 27000000,
  parameter int TICK_HZ  = 1,
  parameter int DISP_HZ  = 2700,
  parameter int DIGITS   = 4,
  parameter int BCD_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  tick,
  output logic                  wrap,
  output logic                  disp_clk
);

  localparam int W    = 4 * DIGITS;
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int HALF = CLK_HZ / (2 * DISP_HZ);
  localparam int PW   = $clog2(DIV);
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [3:0] DIGIT_MAX = (BCD_MODE != 0) ? 4'd9 : 4'hF;

  logic [PW-1:0] presc;
  logic [DW-1:0] disp_cnt;
  logic [W-1:0]  step_value;
  logic [W-1:0]  load_sat;
  logic          step_wrap;
  logic          carry;
  logic          terminal;

  assign terminal = run && (presc == PW'(DIV - 1));

  // Ripple a carry (up) or borrow (down) through the digits; a carry still
  // set after the top digit means every digit was at its limit, i.e. a wrap.
  // Binary mode is the same walk with a digit limit of F.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    step_value = value;
    carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (value[4*i +: 4] == DIGIT_MAX) begin
            step_value[4*i +: 4] = 4'd0;
          end else begin
            step_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (value[4*i +: 4] == 4'd0) begin
            step_value[4*i +: 4] = DIGIT_MAX;
          end else begin
            step_value[4*i +: 4] = value[4*i +: 4] - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  // Loaded digits above 9 are clamped so the BCD count never holds an illegal digit.
  always_comb begin
    load_sat = load_value;
    if (BCD_MODE != 0) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (load_value[4*i +: 4] > 4'd9) load_sat[4*i +: 4] = 4'd9;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        value <= '0;
        presc <= '0;
      end else if (load) begin
        value <= load_sat;
        presc <= '0;
      end else if (terminal) begin
        presc <= '0;
        value <= step_value;
        tick  <= 1'b1;
        wrap  <= step_wrap;
      end else if (run) begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Display divider runs regardless of run/clear/load so the display never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_cnt <= '0;
      disp_clk <= 1'b0;
    end else if (disp_cnt == DW'(HALF - 1)) begin
      disp_cnt <= '0;
      disp_clk <= ~disp_clk;
    end else begin
      disp_cnt <= disp_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_counter_timer_core.sv
// Bench for counter_timer_core: a hex and a BCD instance share stimulus; expected
// ticks are queued with their due cycle and checked by a negedge monitor.
module tb_counter_timer_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       up = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;

  logic [7:0] bin_value, bcd_value;
  logic       bin_tick, bcd_tick, bin_wrap, bcd_wrap, bin_disp, bcd_disp;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int since = -1;

  typedef struct {
    logic [7:0] value;
    logic       wrap;
    int         cyc;
  } exp_t;

  exp_t q_bin[$];
  exp_t q_bcd[$];
  exp_t e_mon;

  counter_timer_core #(
    .CLK_HZ(100), .TICK_HZ(10), .DISP_HZ(10), .DIGITS(2), .BCD_MODE(0)
  ) dut_bin (
    .clk(clk), .rst(rst), .run(run), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .value(bin_value), .tick(bin_tick),
    .wrap(bin_wrap), .disp_clk(bin_disp)
  );

  counter_timer_core #(
    .CLK_HZ(100), .TICK_HZ(10), .DISP_HZ(10), .DIGITS(2), .BCD_MODE(1)
  ) dut_bcd (
    .clk(clk), .rst(rst), .run(run), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .value(bcd_value), .tick(bcd_tick),
    .wrap(bcd_wrap), .disp_clk(bcd_disp)
  );

  always #5 clk = ~clk;

  // Cycle stamp and edges-since-reset count for the display clock model.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) since = 0;
    else if (since >= 0) since = since + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (since >= 0) begin
      check("bin_disp_clk", bin_disp, (since / 5) % 2);
      check("bcd_disp_clk", bcd_disp, (since / 5) % 2);
    end
    if (bin_tick) begin
      if (q_bin.size() == 0) begin
        tests++; fails++;
        $display("FAIL bin_tick_unexpected: tick=1 value=%h at cycle %0d, expected no tick", bin_value, cyc);
      end else begin
        e_mon = q_bin.pop_front();
        check("bin_tick_value", bin_value, e_mon.value);
        check("bin_tick_wrap", bin_wrap, e_mon.wrap);
        check("bin_tick_cycle", cyc, e_mon.cyc);
      end
    end else begin
      check("bin_wrap_without_tick", bin_wrap, 0);
    end
    if (bcd_tick) begin
      if (q_bcd.size() == 0) begin
        tests++; fails++;
        $display("FAIL bcd_tick_unexpected: tick=1 value=%h at cycle %0d, expected no tick", bcd_value, cyc);
      end else begin
        e_mon = q_bcd.pop_front();
        check("bcd_tick_value", bcd_value, e_mon.value);
        check("bcd_tick_wrap", bcd_wrap, e_mon.wrap);
        check("bcd_tick_cycle", cyc, e_mon.cyc);
      end
    end else begin
      check("bcd_wrap_without_tick", bcd_wrap, 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] bv, input logic bw,
                      input logic [7:0] dv, input logic dw, input int at);
    exp_t e;
    e.value = bv; e.wrap = bw; e.cyc = at;
    q_bin.push_back(e);
    e.value = dv; e.wrap = dw;
    q_bcd.push_back(e);
  endtask

  task automatic do_load(input logic [7:0] v, input logic [7:0] exp_bin, input logic [7:0] exp_bcd);
    load = 1'b1;
    load_value = v;
    cycles(1);
    load = 1'b0;
    check("bin_load_value", bin_value, exp_bin);
    check("bcd_load_value", bcd_value, exp_bcd);
    check("bin_load_tick", bin_tick, 0);
    check("bcd_load_tick", bcd_tick, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bin_value"}, bin_value, 0);
    check({tag, "_bcd_value"}, bcd_value, 0);
    check({tag, "_bin_tick"}, bin_tick, 0);
    check({tag, "_bcd_tick"}, bcd_tick, 0);
    check({tag, "_bin_wrap"}, bin_wrap, 0);
    check({tag, "_bcd_wrap"}, bcd_wrap, 0);
  endtask

  initial begin
    cycles(1);
    check_all_zero("reset");
    check("reset_bin_disp", bin_disp, 0);
    check("reset_bcd_disp", bcd_disp, 0);

    // Plain counting from reset: tick every 10 cycles.
    rst = 1'b0; run = 1'b1; up = 1'b1;
    push(8'h01, 0, 8'h01, 0, cyc + 10);
    push(8'h02, 0, 8'h02, 0, cyc + 20);
    push(8'h03, 0, 8'h03, 0, cyc + 30);
    cycles(30);

    // Upward decimal carry and BCD wrap.
    do_load(8'h98, 8'h98, 8'h98);
    push(8'h99, 0, 8'h99, 0, cyc + 10);
    push(8'h9A, 0, 8'h00, 1, cyc + 20);
    cycles(20);

    // Downward borrow, then down-wrap from zero.
    up = 1'b0;
    do_load(8'h10, 8'h10, 8'h10);
    push(8'h0F, 0, 8'h09, 0, cyc + 10);
    cycles(10);
    do_load(8'h00, 8'h00, 8'h00);
    push(8'hFF, 1, 8'h99, 1, cyc + 10);
    cycles(10);

    // Hex up-wrap; BCD load clamps illegal digits.
    up = 1'b1;
    do_load(8'hFF, 8'hFF, 8'h99);
    push(8'h00, 1, 8'h00, 1, cyc + 10);
    cycles(10);
    do_load(8'h5C, 8'h5C, 8'h59);
    do_load(8'hAF, 8'hAF, 8'h99);

    // Pause at prescaler 4: remaining 6 run cycles complete the period.
    cycles(4);
    run = 1'b0;
    cycles(20);
    run = 1'b1;
    push(8'hB0, 0, 8'h00, 1, cyc + 6);
    cycles(6);

    // Clear and load together on a terminal count: clear wins, step is dropped.
    cycles(9);
    clear = 1'b1; load = 1'b1; load_value = 8'h55;
    cycles(1);
    clear = 1'b0; load = 1'b0;
    check_all_zero("clear_terminal");

    // Reset mid-count, then confirm the prescaler restarted from zero.
    do_load(8'h42, 8'h42, 8'h42);
    push(8'h43, 0, 8'h43, 0, cyc + 10);
    cycles(15);
    rst = 1'b1;
    cycles(1);
    check_all_zero("mid_reset");
    check("mid_reset_bin_disp", bin_disp, 0);
    check("mid_reset_bcd_disp", bcd_disp, 0);
    rst = 1'b0;
    push(8'h01, 0, 8'h01, 0, cyc + 10);
    cycles(10);

    run = 1'b0;
    cycles(3);
    check("bin_ticks_outstanding", q_bin.size(), 0);
    check("bcd_ticks_outstanding", q_bcd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_timer_core.md
Name: counter_timer_core

Overview:
- Parametrised seconds/event counter core that drives the quad 7-segment display path. Generalises the fixed 27 MHz, 4-digit hex counter.
- Adds:
  - configurable prescaler and digit count
  - hex or BCD counting
  - up/down direction and run/pause
  - clear and parallel load
  - wrap flag
  - a generated display clock.
- Sits between the board oscillator and the quad_7seg driver. `value` feeds the display number input; `disp_clk` feeds its clock.

Parameters:
- CLK_HZ, 27000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be ≥ 2.
- DISP_HZ, 2700, display clock frequency. HALF = CLK_HZ/(2*DISP_HZ); HALF must be ≥ 1.
- DIGITS, 4, number of 4-bit digits in the count, range 1–8.
- BCD_MODE, 0:
  - 0 = binary count over 4*DIGITS bits (hex display).
  - 1 = each nibble counts 0–9 with decimal carry.

Ports:
- clk  in  1  system clock, 27 MHz onboard oscillator.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler advances and count steps; 0 = pause, all state held.
- up  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clear  in  1  synchronous clear of the count and prescaler.
- load  in  1  synchronous load of `load_value`.
- load_value  in  4*DIGITS  value to load.
- value  out  4*DIGITS  current count.
- tick  out  1  one-cycle pulse on every count step.
- wrap  out  1  one-cycle pulse when a count step wraps.
- disp_clk  out  1  square wave at DISP_HZ.

Behaviour:
- One clock domain, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - `value` = 0, prescaler = 0, `tick` = 0, `wrap` = 0.
  - `disp_clk` = 0, display divider = 0.
- Prescaler:
  - Counts 0..DIV-1 while `run` = 1, then returns to 0.
  - On the cycle the prescaler equals DIV-1 with `run` = 1, a step occurs. `tick` is registered and is high on the following cycle, together with the updated `value`.
  - With `run` = 0 the prescaler holds its value; it does not restart.
- Step, up:
  - Binary mode: `value`+1, modulo 2^(4*DIGITS).
  - BCD mode: the low digit increments; a digit at 9 goes to 0 and carries into the next digit.
  - All digits at maximum (all F or all 9) go to 0 and pulse `wrap`.
- Step, down:
  - Mirror of up. Borrow propagates, with 0 going to F (binary) or 0 going to 9 (BCD).
  - All-zero goes to all-maximum and pulses `wrap`.
- Priority per cycle: `rst` > `clear` > `load` > step.
  - `clear`: `value` = 0, prescaler = 0. No `tick`, no `wrap` that cycle.
  - `load`: `value` = `load_value`, prescaler = 0. No `tick`, no `wrap`.
    - In BCD mode, any loaded nibble > 9 is stored as 9.
  - A step that coincides with `clear` or `load` is discarded.
- `wrap` is only ever high in the same cycle as `tick`.
- Display divider:
  - Free-running, independent of `run`, `clear` and `load`; reset only by `rst`.
  - Counts 0..HALF-1; `disp_clk` toggles on the cycle the divider reaches HALF-1.
  - At the defaults, HALF = 5000: `disp_clk` = 2700 Hz, 50 % duty.
- Latency: `load_value`/`clear` to `value` = 1 cycle. Prescaler terminal count to `value` and `tick` = 1 cycle.
- Reset mid-operation: all state returns to the reset values on the next edge, regardless of the other inputs.

Test Plan:
- Parameters CLK_HZ=100, TICK_HZ=10 (DIV=10), DISP_HZ=10 (HALF=5), DIGITS=2.
  - `rst` 1 cycle, then `run`=1, `up`=1, BCD_MODE=0 → `tick` every 10 cycles; `value` 00, 01, 02…; `disp_clk` toggles every 5 cycles starting from 0.
  - BCD_MODE=1, load 0x98, `up`=1, run 2 ticks → `value` 0x99, then 0x00 with `wrap`=1 on that tick cycle only.
  - BCD_MODE=1, load 0x10, `up`=0, run 1 tick → 0x09. Load 0x00, 1 tick → 0x99 with `wrap`=1.
  - BCD_MODE=0, load 0xFF, `up`=1, 1 tick → 0x00 with `wrap`=1. BCD_MODE=1, load 0xAF → `value` 0x99.
  - Drop `run` at prescaler = 4 for 20 cycles, then raise it → the next `tick` arrives 6 run-cycles later, not 10; `disp_clk` keeps toggling during the pause.
  - Assert `clear` and `load` in the same cycle as a terminal prescaler count → `value` = 0x00, no `tick`. Assert `rst` mid-count → `value`, `tick`, `wrap`, `disp_clk` all 0 on the next edge.
